dbus_mem_responder: RTL and testbench
=====================================

Name: dbus_mem_responder

Overview:
- Responder (slave) end of the core's data-bus handshake. It turns the memory stage's dbus requests into reads and byte-strobed writes on an internal 64-bit-word RAM.
- It inserts a programmable wait latency, then returns one response beat per request.
- It serves as the simulation/FPGA data memory behind the pipeline, and as the stand-in that exercises the core's stall-on-memory logic.

Parameters:
- DEPTH_WORDS, 4096, number of 64-bit RAM words; must be a power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- LATENCY, 2, wait cycles inserted between request capture and the response beat; legal range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dreq  in  dbus_req_t  request: valid, addr[63:0], size (msize_t: MSIZE1/2/4/8), strobe[7:0], data[63:0].
- dresp  out  dbus_resp_t  response: addr_ok, data_ok, data[63:0].
- err  out  1  pulses with data_ok when the request faulted.
- busy  out  1  high while a request is captured and not yet answered.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; wait counter clears to 0.
  - dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, err=0, busy=0.
  - RAM contents are not cleared.
- Protocol rules:
  - Initiator raises dreq.valid and holds all dreq fields stable until it samples data_ok=1.
  - addr_ok and data_ok are always asserted together, for exactly one cycle per request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid=1 at an edge, capture addr, size, strobe and data into registers.
  - Load counter with LATENCY; busy=1.
  - Go to WAIT if LATENCY>0, else RESP.
- WAIT:
  - Decrement counter each cycle; go to RESP when the counter reaches 1 at the edge.
  - If dreq.valid drops (protocol abort), return to IDLE with no write and no response.
- RESP (one cycle):
  - Drive addr_ok=data_ok=1.
  - dresp.data = RAM word at index ((addr-BASE_ADDR)>>3), read before any write in that same cycle.
  - If strobe≠0, commit the write at the closing edge: byte lane i is updated from data[8i+7:8i] iff strobe[i].
  - Next state is IDLE.
- Timing: valid first sampled in IDLE at edge t → data_ok high during cycle t+LATENCY+1, i.e. LATENCY+1 cycles after capture.
- Back-to-back: if valid is still high in the cycle after RESP, it is a new request, captured from IDLE normally. Minimum spacing between responses is LATENCY+2 cycles.
- Fault conditions (any one raises err in the RESP cycle):
  - addr outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS).
  - addr not aligned to size (MSIZE2 needs addr[0]=0, MSIZE4 needs addr[1:0]=0, MSIZE8 needs addr[2:0]=0).
  - strobe bits set outside the lanes covered by size at addr[2:0].
- On a faulted request: data_ok still pulses (so the core never deadlocks), dresp.data=0, and no RAM write.
- Outputs are registered. dresp fields are 0 in every cycle other than RESP.
- reset asserted in WAIT or RESP: the pending write is dropped, and the outputs read reset values at the next edge.
- Address arithmetic is done in 64 bits. The word index uses bits [3+log2(DEPTH_WORDS)-1:3] of the offset; offset wrap-around must fail the range check, never alias.

Decomposition:
- The shared common package already provides dbus_req_t, dbus_resp_t and msize_t.
- Add a pipes-level enum for the responder FSM states, plus an MSIZE→lane-mask helper function. The memory stage reuses that helper for its own strobe generation.
- One sub-module: dmem_ram_64, a single-port 64-bit RAM with 8 byte-write enables and read-before-write.
- The FSM, counter, fault check and response registers stay in the top module.

Test Plan:
- Read after write, LATENCY=2: write addr 0x8000_0010, MSIZE8, strobe 0xFF, data 0x1122334455667788; then read the same addr, strobe 0. data_ok comes 3 cycles after valid, and the read returns 0x1122334455667788 with err=0.
- Partial write: from that word, write MSIZE2 at 0x8000_0012, strobe 0x0C, data 0x0000_0000_ABCD_0000. A subsequent read returns 0x11223344ABCD7788.
- Faults:
  - Read at 0x7FFF_FFF8 gives err=1, data=0, data_ok pulses once.
  - MSIZE4 write at 0x8000_0002 gives err=1, and a reread of that word is unchanged.
- Back-to-back: hold valid high across two requests with LATENCY=0. Responses occur 2 cycles apart, and each addr_ok/data_ok pulse is exactly 1 cycle wide.
- Mid-operation reset: assert reset for 1 cycle while in WAIT with a pending write of 0xDEAD to 0x8000_0020. No data_ok follows, busy=0 next cycle, and a later read of 0x8000_0020 shows the old contents.
- Abort: drop valid in WAIT (LATENCY=3). No response is issued, the FSM returns to IDLE, and the next request is serviced with normal latency.

Source files
------------

// File: rtl/dbus_mem_responder_pkg.sv
// Shared dbus types, responder FSM states and the size-to-lane-mask helper.
// The memory stage reuses msize_lanes() to build its own write strobes.
package dbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_t;

    // Byte lanes touched by an access of the given size, anchored at lane 0.
    function automatic logic [7:0] msize_lanes(input msize_t s);
        logic [7:0] m;
        case (s)
            MSIZE1:  m = 8'h01;
            MSIZE2:  m = 8'h03;
            MSIZE4:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dbus_mem_responder_ram.sv
// Single-port 64-bit RAM, 8 byte enables; read is combinational, write lands
// at the edge, so a read in the same cycle as a write sees the old word.
module dmem_ram_64 #(
    parameter  int unsigned DEPTH = 4096,
    localparam int          AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    be_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 8; i++) begin
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus responder: captures one request, waits LATENCY cycles, then answers with
// a single addr_ok/data_ok beat backed by a byte-strobed 64-bit word RAM.
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err,
    output logic       busy
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    rsp_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    msize_t      size_q, size_d;
    logic [7:0]  strb_q, strb_d;
    logic [63:0] wdat_q, wdat_d;
    dbus_resp_t  resp_q, resp_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [63:0] off_d;
    logic [3:0]  nbytes_d;
    logic [7:0]  lanes_d;
    logic        fault_d;
    logic [63:0] rdata;
    logic [7:0]  ram_be;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        strb_d  = strb_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    addr_d  = dreq.addr;
                    size_d  = dreq.size;
                    strb_d  = dreq.strobe;
                    wdat_d  = dreq.data;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!dreq.valid)          state_d = IDLE;
                else if (cnt_q <= 4'd1)   state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fault check runs on the next-state request so the response can be
    // registered on the same edge that enters RESP, even with zero latency.
    // Wrapped offsets (addr below BASE) come out huge and fail the range test.
    always_comb begin
        off_d    = addr_d - BASE_ADDR;
        nbytes_d = 4'd1 << size_d;
        lanes_d  = msize_lanes(size_d) << addr_d[2:0];
        fault_d  = (off_d >= SPAN)
                || ((addr_d[2:0] & 3'(nbytes_d - 4'd1)) != 3'd0)
                || ((strb_d & ~lanes_d) != 8'h00);
    end

    always_comb begin
        resp_d = '0;
        err_d  = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_d == RESP) begin
            resp_d.addr_ok = 1'b1;
            resp_d.data_ok = 1'b1;
            resp_d.data    = fault_d ? 64'h0 : rdata;
            err_d          = fault_d;
        end
    end

    // Write commits at the edge closing RESP; a reset on that edge drops it.
    assign ram_be = (state_q == RESP && !err_q && !reset) ? strb_q : 8'h00;

    dmem_ram_64 #(
        .DEPTH(DEPTH_WORDS)
    ) u_ram (
        .clk_i  (clk),
        .addr_i (off_d[3 +: AW]),
        .be_i   (ram_be),
        .wdata_i(wdat_q),
        .rdata_o(rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        size_q <= size_d;
        strb_q <= strb_d;
        wdat_q <= wdat_d;
    end

    assign dresp = resp_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 0, 3) share clock and reset;
// expectations are queued at issue and checked when data_ok appears.
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    typedef struct {
        int          dut;
        int          cyc;
        int          lat;
        logic [63:0] data;
        logic        has_d;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    dbus_req_t  req    [3];
    dbus_resp_t rsp    [3];
    logic       err_w  [3];
    logic       busy_w [3];

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [63:0] mdl [int];
    int lat_of  [3] = '{2, 0, 3};
    int n_resp  [3] = '{0, 0, 0};
    int ok_last [3] = '{0, 0, 0};
    int ok_prev [3] = '{0, 0, 0};
    logic prev_ok [3] = '{1'b0, 1'b0, 1'b0};
    int n_chk = 0, n_pass = 0, cyc = 0;
    int nb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_mem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(rst), .dreq(req[0]), .dresp(rsp[0]), .err(err_w[0]), .busy(busy_w[0]));
    dbus_mem_responder #(.LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(rst), .dreq(req[1]), .dresp(rsp[1]), .err(err_w[1]), .busy(busy_w[1]));
    dbus_mem_responder #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(rst), .dreq(req[2]), .dresp(rsp[2]), .err(err_w[2]), .busy(busy_w[2]));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic wait_rsp(input int k);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = (rsp[k].data_ok === 1'b1);
        end
        if (!got) begin
            chk("rsp_timeout", 64'(rsp[k].data_ok), 64'd1);
            if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive a request and hold it until the response beat has been sampled.
    task automatic send(input int k, input logic [63:0] a, input msize_t s,
                        input logic [7:0] st, input logic [63:0] d, input logic ee);
        exp_t e;
        int key;
        logic [63:0] w;
        e.dut = k; e.cyc = cyc; e.lat = lat_of[k]; e.err = ee;
        e.has_d = 1'b1; e.data = 64'h0;
        if (!ee) begin
            key = k * 1000000 + int'((a - BASE) >> 3);
            if (mdl.exists(key)) begin
                w = mdl[key];
                e.data = w;
                for (int i = 0; i < 8; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
                mdl[key] = w;
            end else begin
                e.has_d = 1'b0;
                if (st == 8'hFF) mdl[key] = d;
            end
        end
        exp_q.push_back(e);
        req[k].valid  = 1'b1;
        req[k].addr   = a;
        req[k].size   = s;
        req[k].strobe = st;
        req[k].data   = d;
        wait_rsp(k);
    endtask

    task automatic txn(input int k, input logic [63:0] a, input msize_t s,
                       input logic [7:0] st, input logic [63:0] d, input logic ee);
        send(k, a, s, st, d, ee);
        req[k] = '0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rsp[k].data_ok === 1'b1) begin
                n_resp[k]++;
                ok_prev[k] = ok_last[k];
                ok_last[k] = cyc;
                chk("pulse_width", 64'(prev_ok[k]), 64'd0);
                chk("addr_ok", 64'(rsp[k].addr_ok), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp[k].data_ok), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_dut", 64'(k), 64'(mon_e.dut));
                    chk("latency", 64'(cyc - mon_e.cyc), 64'(mon_e.lat + 1));
                    chk("err", 64'(err_w[k]), 64'(mon_e.err));
                    if (mon_e.has_d) chk("rdata", rsp[k].data, mon_e.data);
                end
            end else begin
                chk("idle_zero", 64'({rsp[k].addr_ok, err_w[k], rsp[k].data !== 64'h0}), 64'd0);
            end
            prev_ok[k] = rsp[k].data_ok;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) req[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_data_ok", 64'(rsp[k].data_ok), 64'd0);
            chk("rst_data", rsp[k].data, 64'h0);
            chk("rst_busy", 64'(busy_w[k]), 64'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // LATENCY=2: read after write, partial write, faults, boundaries
        txn(0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788, 1'b0);
        txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0);
        txn(0, 64'h8000_0012, MSIZE2, 8'h0C, 64'h0000_0000_ABCD_0000, 1'b0);
        txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0);
        txn(0, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 1'b1);
        txn(0, 64'h8000_0000, MSIZE8, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
        txn(0, 64'h8000_0002, MSIZE4, 8'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        txn(0, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 1'b0);
        txn(0, 64'h8000_7FF8, MSIZE8, 8'h00, 64'h0, 1'b0);
        txn(0, 64'h8000_8000, MSIZE8, 8'h00, 64'h0, 1'b1);
        txn(0, 64'h8000_0011, MSIZE1, 8'h01, 64'h0, 1'b1);
        txn(0, 64'h8000_0011, MSIZE1, 8'h02, 64'h0000_0000_0000_EE00, 1'b0);
        txn(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0);
        txn(0, 64'hFFFF_FFFF_FFFF_FFF8, MSIZE8, 8'h00, 64'h0, 1'b1);

        // Reset while a write waits: no response, old contents survive
        txn(0, 64'h8000_0020, MSIZE8, 8'hFF, 64'h0000_0000_0BAD_F00D, 1'b0);
        nb = n_resp[0];
        req[0].valid = 1'b1; req[0].addr = 64'h8000_0020; req[0].size = MSIZE2;
        req[0].strobe = 8'h03; req[0].data = 64'h0000_0000_0000_DEAD;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req[0] = '0;
        @(negedge clk);
        chk("rst_wait_busy", 64'(busy_w[0]), 64'd0);
        repeat (5) @(negedge clk);
        chk("rst_wait_no_rsp", 64'(n_resp[0] - nb), 64'd0);
        @(posedge clk); #1;
        txn(0, 64'h8000_0020, MSIZE8, 8'h00, 64'h0, 1'b0);

        // LATENCY=0: back-to-back with valid held high
        txn(1, 64'h8000_0040, MSIZE8, 8'hFF, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0);
        txn(1, 64'h8000_0048, MSIZE8, 8'hFF, 64'hB0B1_B2B3_B4B5_B6B7, 1'b0);
        send(1, 64'h8000_0040, MSIZE8, 8'h00, 64'h0, 1'b0);
        send(1, 64'h8000_0048, MSIZE8, 8'h00, 64'h0, 1'b0);
        req[1] = '0;
        chk("b2b_spacing", 64'(ok_last[1] - ok_prev[1]), 64'd2);

        // LATENCY=3: abort in WAIT, then a normal request
        txn(2, 64'h8000_0080, MSIZE8, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1'b0);
        nb = n_resp[2];
        req[2].valid = 1'b1; req[2].addr = 64'h8000_0080; req[2].size = MSIZE8;
        req[2].strobe = 8'hFF; req[2].data = 64'h0;
        @(posedge clk); #1;
        @(posedge clk); #1 req[2].valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 64'(busy_w[2]), 64'd1);
        @(negedge clk);
        chk("abort_busy_after", 64'(busy_w[2]), 64'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_rsp", 64'(n_resp[2] - nb), 64'd0);
        @(posedge clk); #1;
        txn(2, 64'h8000_0080, MSIZE8, 8'h00, 64'h0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
